// File: rtl/battle_timer_hp.sv
`default_nettype none
// ============================================================================
// Module   : battle_timer_hp
// Brief    : Battle HP tracker, survival countdown and i-frame window.
// Revision : 1.0 - initial release
// ============================================================================
module battle_timer_hp #(
    parameter int MAX_HP         = 10,
    parameter int DMG            = 1,
    parameter int FPS            = 60,
    parameter int BATTLE_SECONDS = 30,
    parameter int IFRAMES        = 30
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [3:0] status,
    input  logic       frame_tick,
    input  logic       hit,
    output logic [3:0] HP,
    output logic       time_up,
    output logic [7:0] time_left,
    output logic       invuln
);

    localparam int         c_SUB_W    = (FPS > 1) ? $clog2(FPS) : 1;
    localparam logic [3:0] c_BATTLE   = 4'd5;
    localparam logic [3:0] c_MAX_HP   = 4'(MAX_HP);
    localparam logic [3:0] c_DMG      = 4'(DMG);
    localparam logic [7:0] c_SECONDS  = 8'(BATTLE_SECONDS);
    localparam logic [7:0] c_IFRAMES  = 8'(IFRAMES);
    localparam logic [c_SUB_W-1:0] c_SUB_LAST = c_SUB_W'(FPS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FIGHT     = 3'd1,
        INVULN    = 3'd2,
        DONE_WIN  = 3'd3,
        DONE_LOSE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         prev_status_q;
    logic [3:0]         hp_q, hp_d;
    logic [7:0]         tl_q, tl_d;
    logic [c_SUB_W-1:0] sub_q, sub_d;
    logic [7:0]         ifr_q, ifr_d;
    logic               time_up_q, time_up_d;
    logic               invuln_q, invuln_d;

    logic               w_in_battle;
    logic               w_entry;
    logic               w_wrap;
    logic               w_timeout;
    logic               w_hit_acc;
    logic [3:0]         w_hp_hit;

    assign w_in_battle = (status == c_BATTLE);
    assign w_entry     = w_in_battle && (prev_status_q != c_BATTLE);
    assign w_wrap      = frame_tick && (sub_q == c_SUB_LAST);
    assign w_timeout   = w_wrap && (tl_q == 8'd1);
    assign w_hit_acc   = hit && (state_q == FIGHT);
    assign w_hp_hit    = (hp_q > c_DMG) ? (hp_q - c_DMG) : 4'd0;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            prev_status_q <= 4'd0;
            hp_q          <= c_MAX_HP;
            tl_q          <= 8'd0;
            sub_q         <= '0;
            ifr_q         <= 8'd0;
            time_up_q     <= 1'b0;
            invuln_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_status_q <= status;
            hp_q          <= hp_d;
            tl_q          <= tl_d;
            sub_q         <= sub_d;
            ifr_q         <= ifr_d;
            time_up_q     <= time_up_d;
            invuln_q      <= invuln_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hp_d      = hp_q;
        tl_d      = tl_q;
        sub_d     = sub_q;
        ifr_d     = ifr_q;
        time_up_d = time_up_q;
        invuln_d  = invuln_q;

        if (w_entry) begin
            state_d   = FIGHT;
            hp_d      = c_MAX_HP;
            tl_d      = c_SECONDS;
            sub_d     = '0;
            ifr_d     = 8'd0;
            time_up_d = 1'b0;
            invuln_d  = 1'b0;
        end else if (!w_in_battle) begin
            state_d   = IDLE;
            time_up_d = 1'b0;
            invuln_d  = 1'b0;
        end else if (state_q == FIGHT || state_q == INVULN) begin
            if (frame_tick) begin
                sub_d = w_wrap ? '0 : sub_q + 1'b1;
                if (w_wrap) tl_d = tl_q - 8'd1;
            end
            if (w_hit_acc) hp_d = w_hp_hit;

            // Damage resolves before the timeout so a killing blow on the last tick loses.
            if (w_hit_acc && w_hp_hit == 4'd0) begin
                state_d  = DONE_LOSE;
                invuln_d = 1'b0;
            end else if (w_timeout) begin
                state_d   = DONE_WIN;
                time_up_d = 1'b1;
                invuln_d  = 1'b0;
            end else if (w_hit_acc) begin
                state_d  = INVULN;
                ifr_d    = c_IFRAMES;
                invuln_d = 1'b1;
            end else if (state_q == INVULN && frame_tick) begin
                ifr_d = ifr_q - 8'd1;
                if (ifr_q == 8'd1) begin
                    state_d  = FIGHT;
                    invuln_d = 1'b0;
                end
            end
        end
    end

    assign HP        = hp_q;
    assign time_up   = time_up_q;
    assign time_left = tl_q;
    assign invuln    = invuln_q;

endmodule
`default_nettype wire

// File: tb/tb_battle_timer_hp.sv
`default_nettype none
// ============================================================================
// Module   : tb_battle_timer_hp
// Brief    : Directed vector table plus multi-cycle sequences for battle_timer_hp.
// Revision : 1.0 - initial release
// ============================================================================
module tb_battle_timer_hp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] status;
    logic       frame_tick;
    logic       hit;
    logic [3:0] hp;
    logic       time_up;
    logic [7:0] time_left;
    logic       invuln;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    battle_timer_hp dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .status     (status),
        .frame_tick (frame_tick),
        .hit        (hit),
        .HP         (hp),
        .time_up    (time_up),
        .time_left  (time_left),
        .invuln     (invuln)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] st;
        logic       ft;
        logic       hit;
        logic [3:0] hp;
        logic       tu;
        logic [7:0] tl;
        logic       inv;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] st, input logic ft, input logic h);
        rst_n      = r;
        status     = st;
        frame_tick = ft;
        hit        = h;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        hit        = 1'b0;
    endtask

    // One frame tick (optionally with a hit) followed by a quiet cycle.
    task automatic tick(input logic h);
        step(1'b1, 4'd5, 1'b1, h);
        step(1'b1, 4'd5, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic enter(input string name);
        step(1'b1, 4'd4, 1'b0, 1'b0);
        step(1'b1, 4'd5, 1'b0, 1'b0);
        chk({name, "_hp"}, int'(hp), 10);
        chk({name, "_tl"}, int'(time_left), 30);
    endtask

    initial begin
        rst_n = 1'b0; status = 4'd0; frame_tick = 1'b0; hit = 1'b0;

        //         rst   st     ft    hit   hp     tu    tl      inv
        vecs[0]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd10, 1'b0, 8'd0,  1'b0};
        vecs[1]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd10, 1'b0, 8'd0,  1'b0};
        vecs[2]  = '{1'b1, 4'd4, 1'b1, 1'b1, 4'd10, 1'b0, 8'd0,  1'b0};
        vecs[3]  = '{1'b1, 4'd5, 1'b0, 1'b0, 4'd10, 1'b0, 8'd30, 1'b0};
        vecs[4]  = '{1'b1, 4'd5, 1'b0, 1'b1, 4'd9,  1'b0, 8'd30, 1'b1};
        vecs[5]  = '{1'b1, 4'd5, 1'b0, 1'b1, 4'd9,  1'b0, 8'd30, 1'b1};
        vecs[6]  = '{1'b1, 4'd5, 1'b1, 1'b1, 4'd9,  1'b0, 8'd30, 1'b1};
        vecs[7]  = '{1'b1, 4'd7, 1'b0, 1'b0, 4'd9,  1'b0, 8'd30, 1'b0};
        vecs[8]  = '{1'b1, 4'd7, 1'b1, 1'b1, 4'd9,  1'b0, 8'd30, 1'b0};
        vecs[9]  = '{1'b1, 4'd4, 1'b0, 1'b0, 4'd9,  1'b0, 8'd30, 1'b0};
        vecs[10] = '{1'b1, 4'd5, 1'b1, 1'b1, 4'd10, 1'b0, 8'd30, 1'b0};
        vecs[11] = '{1'b1, 4'd5, 1'b1, 1'b0, 4'd10, 1'b0, 8'd30, 1'b0};
        vecs[12] = '{1'b0, 4'd5, 1'b0, 1'b0, 4'd10, 1'b0, 8'd0,  1'b0};
        vecs[13] = '{1'b1, 4'd5, 1'b0, 1'b0, 4'd10, 1'b0, 8'd30, 1'b0};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rst_n, vecs[i].st, vecs[i].ft, vecs[i].hit);
            chk($sformatf("vec%0d_hp", i),  int'(hp),        int'(vecs[i].hp));
            chk($sformatf("vec%0d_tu", i),  int'(time_up),   int'(vecs[i].tu));
            chk($sformatf("vec%0d_tl", i),  int'(time_left), int'(vecs[i].tl));
            chk($sformatf("vec%0d_inv", i), int'(invuln),    int'(vecs[i].inv));
        end

        // Full survival countdown from the fresh entry of the last vector.
        ticks(59);
        chk("cd59_tl", int'(time_left), 30);
        tick(1'b0);
        chk("cd60_tl", int'(time_left), 29);
        ticks(1739);
        chk("cd1799_tl", int'(time_left), 1);
        chk("cd1799_tu", int'(time_up), 0);
        tick(1'b0);
        chk("cd1800_tl", int'(time_left), 0);
        chk("cd1800_tu", int'(time_up), 1);
        ticks(100);
        tick(1'b1);
        chk("win_hold_tu", int'(time_up), 1);
        chk("win_hold_hp", int'(hp), 10);

        // Invulnerability window.
        enter("iw_entry");
        step(1'b1, 4'd5, 1'b0, 1'b1);
        chk("iw_hit1_hp", int'(hp), 9);
        chk("iw_hit1_inv", int'(invuln), 1);
        ticks(10);
        step(1'b1, 4'd5, 1'b0, 1'b1);
        chk("iw_hit2_hp", int'(hp), 9);
        ticks(19);
        chk("iw_29_inv", int'(invuln), 1);
        tick(1'b0);
        chk("iw_30_inv", int'(invuln), 0);
        step(1'b1, 4'd5, 1'b0, 1'b1);
        chk("iw_hit3_hp", int'(hp), 8);

        // Ten accepted hits to defeat, then the lose state holds.
        enter("lose_entry");
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 4'd5, 1'b0, 1'b1);
            chk($sformatf("lose_hit%0d_hp", i), int'(hp), 10 - i);
            if (i < 10) ticks(30);
        end
        chk("lose_inv", int'(invuln), 0);
        chk("lose_tl", int'(time_left), 26);
        for (int i = 0; i < 1800; i++) tick(1'b1);
        chk("lose_hold_tu", int'(time_up), 0);
        chk("lose_hold_hp", int'(hp), 0);
        chk("lose_hold_tl", int'(time_left), 26);

        // Killing blow on the final tick.
        enter("kb_entry");
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 4'd5, 1'b0, 1'b1);
            ticks(30);
        end
        chk("kb_pre_hp", int'(hp), 1);
        ticks(1529);
        chk("kb_pre_tl", int'(time_left), 1);
        tick(1'b1);
        chk("kb_hp", int'(hp), 0);
        chk("kb_tu", int'(time_up), 0);

        // Non-lethal hit on the final tick wins without entering INVULN.
        enter("nl_entry");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'd5, 1'b0, 1'b1);
            ticks(30);
        end
        chk("nl_pre_hp", int'(hp), 5);
        ticks(1649);
        tick(1'b1);
        chk("nl_hp", int'(hp), 4);
        chk("nl_tu", int'(time_up), 1);
        chk("nl_inv", int'(invuln), 0);
        chk("nl_tl", int'(time_left), 0);

        // Leaving battle freezes state; re-entry reloads; reset mid-fight.
        enter("lv_entry");
        step(1'b1, 4'd5, 1'b0, 1'b1);
        ticks(60);
        step(1'b1, 4'd7, 1'b1, 1'b1);
        chk("lv_hp", int'(hp), 9);
        chk("lv_tl", int'(time_left), 29);
        chk("lv_inv", int'(invuln), 0);
        chk("lv_tu", int'(time_up), 0);
        enter("lv_reentry");
        step(1'b1, 4'd5, 1'b0, 1'b1);
        step(1'b0, 4'd5, 1'b0, 1'b0);
        chk("rst_hp", int'(hp), 10);
        chk("rst_tl", int'(time_left), 0);
        chk("rst_inv", int'(invuln), 0);
        chk("rst_tu", int'(time_up), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
